serial_port: RTL and testbench

Device-side endpoint of the processor's byte-serial IO interface: accepts bytes written by the processor, transmits them as 8N1 UART frames, and receives UART frames into a buffer the processor polls and reads. It sits between the processor's data-memory serial ports and the board UART pins. It decouples the single-cycle core from bit timing through two small byte FIFOs.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/byte_fifo.sv | 49 ++++
 rtl/serial_port.sv | 241 ++++++++++++++++++++++++
 tb/tb_serial_port.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the byte-serial UART endpoint.
package serial_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_CNT_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with wrap-bit pointers and a combinational head view.
// A push is accepted when not full, or when a pop happens in the same cycle;
// a pop is accepted when not empty. Head reads zero while empty.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] wdata,
  output logic [UART_DATA_BITS-1:0] head,
  output logic                      full,
  output logic                      empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_W:0]           wr_ptr;
  logic [ADDR_W:0]           rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // Pointer and storage update; storage is cleared so head is defined after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= wdata;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/serial_port.sv
// Processor-side byte port bridged to an 8N1 UART through a TX and an RX FIFO.
//
// Handshake: the processor may write when cpu_ready_out=1 (TX FIFO not full)
// and the byte is taken on that clock edge; it may read when cpu_valid_out=1
// (RX FIFO not empty), cpu_rdata_out is the head and is consumed on the edge
// where cpu_rden_in=1. Both flags come from registered FIFO pointers only.
module serial_port
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] cpu_wdata_in,
  input  logic                      cpu_wren_in,
  input  logic                      cpu_rden_in,
  output logic [UART_DATA_BITS-1:0] cpu_rdata_out,
  output logic                      cpu_valid_out,
  output logic                      cpu_ready_out,
  input  logic                      uart_rx_in,
  output logic                      uart_tx_out
);

  localparam int                   CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

  // ---------------- FIFOs ----------------
  logic [UART_DATA_BITS-1:0] tx_head;
  logic                      tx_full;
  logic                      tx_empty;
  logic                      tx_pop;
  logic [UART_DATA_BITS-1:0] rx_head;
  logic                      rx_full;
  logic                      rx_empty;
  logic                      rx_push;
  logic [UART_DATA_BITS-1:0] rx_shift;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cpu_wren_in),
    .pop   (tx_pop),
    .wdata (cpu_wdata_in),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // An overrun (push while full without a same-cycle read) drops the new byte.
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push && (!rx_full || cpu_rden_in)),
    .pop   (cpu_rden_in),
    .wdata (rx_shift),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign cpu_ready_out = !tx_full;
  assign cpu_valid_out = !rx_empty;
  assign cpu_rdata_out = rx_head;

  // ---------------- TX path ----------------
  tx_state_t                 tx_state, tx_state_n;
  logic [CNT_W-1:0]          tx_cnt, tx_cnt_n;
  logic [BIT_CNT_W-1:0]      tx_bit, tx_bit_n;
  logic [UART_DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                      tx_line, tx_line_n;

  assign uart_tx_out = tx_line;

  // TX state register; the line itself is registered so it never glitches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next state: frame timing, FIFO pops, and back-to-back start after stop.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_cnt_n   = '0;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == LAST_BIT) begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = {1'b0, tx_shift[UART_DATA_BITS-1:1]};
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_line_n  = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: begin
        tx_line_n  = 1'b1;
        tx_state_n = TX_IDLE;
      end
    endcase
  end

  // ---------------- RX path ----------------
  logic                      rx_meta;
  logic                      rx_sync;
  rx_state_t                 rx_state, rx_state_n;
  logic [CNT_W-1:0]          rx_cnt, rx_cnt_n;
  logic [BIT_CNT_W-1:0]      rx_bit, rx_bit_n;
  logic [UART_DATA_BITS-1:0] rx_shift_n;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_in;
      rx_sync <= rx_meta;
    end
  end

  // RX state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: the detecting cycle counts as the first start-bit cycle,
  // so the start check lands mid-bit and data/stop follow one bit apart.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_n   = CNT_W'(1);
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_MID) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[UART_DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
          else                    rx_bit_n   = rx_bit + 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_push    = rx_sync;
          rx_state_n = RX_IDLE;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port with CLKS_PER_BIT=16 and FIFO_DEPTH=4.
module tb_serial_port;

  logic       clock;
  logic       reset;
  logic [7:0] cpu_wdata_in;
  logic       cpu_wren_in;
  logic       cpu_rden_in;
  logic [7:0] cpu_rdata_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;
  logic       uart_rx_in;
  logic       uart_tx_out;

  int         vectors;
  int         miscompares;
  logic [7:0] exp_q[$];

  serial_port #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_wdata_in  (cpu_wdata_in),
    .cpu_wren_in   (cpu_wren_in),
    .cpu_rden_in   (cpu_rden_in),
    .cpu_rdata_out (cpu_rdata_out),
    .cpu_valid_out (cpu_valid_out),
    .cpu_ready_out (cpu_ready_out),
    .uart_rx_in    (uart_rx_in),
    .uart_tx_out   (uart_tx_out)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- drivers ----------------
  // Starts at the negedge where the start bit is first visible (off negedges
  // already elapsed) and checks each of the 10 bits at its middle.
  task automatic check_frame(input logic [7:0] b, input int off, input string tag);
    for (int k = 0; k < 10; k++) begin
      logic e;
      repeat ((k == 0) ? 8 - off : 8) @(negedge clock);
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk($sformatf("%s_bit%0d", tag, k), {7'b0, uart_tx_out}, {7'b0, e});
      repeat (8) @(negedge clock);
    end
  endtask

  // Drives start + 8 data bits, then leaves the line at the stop value.
  task automatic send_head(input logic [7:0] b, input logic stop_v);
    uart_rx_in = 1'b0;
    repeat (16) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      uart_rx_in = b[k];
      repeat (16) @(negedge clock);
    end
    uart_rx_in = stop_v;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_head(b, 1'b1);
    repeat (16) @(negedge clock);
    if (exp_q.size() < 4) exp_q.push_back(b);
  endtask

  // Reads out everything the scoreboard expects, then checks the FIFO is empty.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      chk({tag, "_valid"}, {7'b0, cpu_valid_out}, 8'h01);
      chk({tag, "_data"}, cpu_rdata_out, exp_q.pop_front());
      cpu_rden_in = 1'b1;
      @(negedge clock);
      cpu_rden_in = 1'b0;
    end
    chk({tag, "_empty"}, {7'b0, cpu_valid_out}, 8'h00);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    cpu_wdata_in = 8'h00;
    cpu_wren_in  = 1'b0;
    cpu_rden_in  = 1'b0;
    uart_rx_in   = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    chk("rst_tx_line", {7'b0, uart_tx_out},   8'h01);
    chk("rst_ready",   {7'b0, cpu_ready_out}, 8'h01);
    chk("rst_valid",   {7'b0, cpu_valid_out}, 8'h00);
    chk("rst_rdata",   cpu_rdata_out,         8'h00);

    // Single TX of A5: line falls one cycle after the write edge.
    cpu_wdata_in = 8'hA5;
    cpu_wren_in  = 1'b1;
    @(negedge clock);
    cpu_wren_in = 1'b0;
    chk("tx1_still_idle", {7'b0, uart_tx_out}, 8'h01);
    @(negedge clock);
    chk("tx1_start", {7'b0, uart_tx_out}, 8'h00);
    check_frame(8'hA5, 0, "tx1");
    chk("tx1_idle_after", {7'b0, uart_tx_out}, 8'h01);
    chk("tx1_ready", {7'b0, cpu_ready_out}, 8'h01);

    // Back-pressure: six writes, the sixth lands on a full FIFO.
    for (int i = 0; i < 6; i++) begin
      if (i == 1) chk("bp_idle_w1", {7'b0, uart_tx_out}, 8'h01);
      if (i == 2) chk("bp_start",   {7'b0, uart_tx_out}, 8'h00);
      if (i == 5) chk("bp_full",    {7'b0, cpu_ready_out}, 8'h00);
      cpu_wdata_in = 8'(i + 1);
      cpu_wren_in  = 1'b1;
      @(negedge clock);
    end
    cpu_wren_in = 1'b0;
    chk("bp_still_full", {7'b0, cpu_ready_out}, 8'h00);
    check_frame(8'h01, 4, "bp1");
    check_frame(8'h02, 0, "bp2");
    check_frame(8'h03, 0, "bp3");
    check_frame(8'h04, 0, "bp4");
    check_frame(8'h05, 0, "bp5");
    chk("bp_idle_800", {7'b0, uart_tx_out}, 8'h01);
    chk("bp_ready",    {7'b0, cpu_ready_out}, 8'h01);
    repeat (20) @(negedge clock);
    chk("bp_no_sixth", {7'b0, uart_tx_out}, 8'h01);

    // RX of 3C: push lands 154 cycles after the start edge.
    send_head(8'h3C, 1'b1);
    repeat (9) @(negedge clock);
    chk("rx_not_yet", {7'b0, cpu_valid_out}, 8'h00);
    @(negedge clock);
    chk("rx_valid", {7'b0, cpu_valid_out}, 8'h01);
    chk("rx_data",  cpu_rdata_out, 8'h3C);
    repeat (6) @(negedge clock);
    cpu_rden_in = 1'b1;
    @(negedge clock);
    cpu_rden_in = 1'b0;
    chk("rx_popped", {7'b0, cpu_valid_out}, 8'h00);
    chk("rx_rdata0", cpu_rdata_out, 8'h00);

    // Short low glitch: rejected at the start midpoint.
    uart_rx_in = 1'b0;
    repeat (4) @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (40) @(negedge clock);
    chk("rx_glitch", {7'b0, cpu_valid_out}, 8'h00);

    // Framing error: stop bit low through its sample point, then idle.
    send_head(8'h77, 1'b0);
    repeat (10) @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (30) @(negedge clock);
    chk("rx_framing", {7'b0, cpu_valid_out}, 8'h00);

    // Overrun: five frames, only the first four are kept.
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i));
    chk("ovr_full_head", cpu_rdata_out, 8'h10);
    drain("ovr");

    // Full FIFO with a read on the push edge: both happen.
    for (int i = 0; i < 4; i++) send_frame(8'(8'h20 + i));
    send_head(8'h24, 1'b1);
    repeat (9) @(negedge clock);
    chk("sim_head_before", cpu_rdata_out, 8'h20);
    cpu_rden_in = 1'b1;
    @(negedge clock);
    cpu_rden_in = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h24);
    chk("sim_head_after", cpu_rdata_out, 8'h21);
    repeat (6) @(negedge clock);
    drain("sim");

    // Reset in the middle of a TX frame forces the line high at once.
    cpu_wdata_in = 8'h00;
    cpu_wren_in  = 1'b1;
    @(negedge clock);
    cpu_wren_in = 1'b0;
    repeat (40) @(negedge clock);
    chk("mid_tx_low", {7'b0, uart_tx_out}, 8'h00);
    reset = 1'b0;
    #1;
    chk("mid_rst_line",  {7'b0, uart_tx_out},   8'h01);
    chk("mid_rst_ready", {7'b0, cpu_ready_out}, 8'h01);
    @(negedge clock);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    chk("mid_rst_idle", {7'b0, uart_tx_out}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
